mips_control_fsm: RTL and testbench

//  Multicycle MIPS main controller plus ALU decoder. Sits directly upstream of alu:

---
 rtl/mips_control_fsm.sv | 110 +++++++++++
 tb/tb_mips_control_fsm.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/mips_control_fsm.sv
// mips_control_fsm: multicycle MIPS main controller (Moore FSM) with ALU decoder
module mips_control_fsm (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       iord,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic       pc_en,
  output logic [2:0] alu_control,
  output logic [3:0] state
);
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_MEMADR  = 4'd2;
  localparam logic [3:0] S_MEMRD   = 4'd3;
  localparam logic [3:0] S_MEMWB   = 4'd4;
  localparam logic [3:0] S_MEMWR   = 4'd5;
  localparam logic [3:0] S_EXECUTE = 4'd6;
  localparam logic [3:0] S_ALUWB   = 4'd7;
  localparam logic [3:0] S_BRANCH  = 4'd8;
  localparam logic [3:0] S_ADDIEX  = 4'd9;
  localparam logic [3:0] S_ADDIWB  = 4'd10;
  localparam logic [3:0] S_JUMP    = 4'd11;

  logic [3:0] state_q, state_d;
  logic       pc_write, branch;
  logic [1:0] alu_op;

  always_ff @(posedge clk or posedge reset)
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:   state_d = S_DECODE;
      S_DECODE:
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      S_MEMADR:  state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   state_d = S_MEMWB;
      S_EXECUTE: state_d = S_ALUWB;
      S_ADDIEX:  state_d = S_ADDIWB;
      default:   state_d = S_FETCH;
    endcase
  end

  always_comb begin
    iord       = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    pc_src     = 2'b00;
    pc_write   = 1'b0;
    branch     = 1'b0;
    alu_op     = 2'b00;
    case (state_q)
      S_FETCH:   begin alu_src_b = 2'b01; ir_write = 1'b1; pc_write = 1'b1; end
      S_DECODE:  alu_src_b = 2'b11;
      S_MEMADR,
      S_ADDIEX:  begin alu_src_a = 1'b1; alu_src_b = 2'b10; end
      S_MEMRD:   iord = 1'b1;
      S_MEMWB:   begin mem_to_reg = 1'b1; reg_write = 1'b1; end
      S_MEMWR:   begin iord = 1'b1; mem_write = 1'b1; end
      S_EXECUTE: begin alu_src_a = 1'b1; alu_op = 2'b10; end
      S_ALUWB:   begin reg_dst = 1'b1; reg_write = 1'b1; end
      S_BRANCH:  begin alu_src_a = 1'b1; alu_op = 2'b01; pc_src = 2'b01; branch = 1'b1; end
      S_ADDIWB:  reg_write = 1'b1;
      S_JUMP:    begin pc_src = 2'b10; pc_write = 1'b1; end
      default:   ;
    endcase
  end

  // funct only matters for R-type execution; everything else adds or subtracts
  always_comb
    alu_control = (alu_op == 2'b01)     ? 3'b110 :
                  (alu_op != 2'b10)     ? 3'b010 :
                  (funct == 6'b100010)  ? 3'b110 :
                  (funct == 6'b100100)  ? 3'b000 :
                  (funct == 6'b100101)  ? 3'b001 :
                  (funct == 6'b101010)  ? 3'b111 : 3'b010;

  assign pc_en = pc_write | (branch & zero);
  assign state = state_q;
endmodule

// File: tb/tb_mips_control_fsm.sv
// tb_mips_control_fsm: table-driven per-cycle check of state and all control outputs
module tb_mips_control_fsm;
  logic       clk = 1'b0, reset = 1'b1, zero = 1'b0;
  logic [5:0] opcode = 6'd0, funct = 6'd0;
  logic       iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, pc_en;
  logic [1:0] alu_src_b, pc_src;
  logic [2:0] alu_control;
  logic [3:0] state;
  logic [14:0] got;
  int checks = 0, failures = 0;

  mips_control_fsm dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .iord(iord), .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .pc_src(pc_src), .pc_en(pc_en),
    .alu_control(alu_control), .state(state)
  );

  always #5 clk = ~clk;

  // {iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, pc_src, pc_en, alu_control}
  assign got = {iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a,
                alu_src_b, pc_src, pc_en, alu_control};

  localparam logic [14:0] FE = 15'b0010000_01_00_1_010;
  localparam logic [14:0] DE = 15'b0000000_11_00_0_010;
  localparam logic [14:0] MA = 15'b0000001_10_00_0_010;
  localparam logic [14:0] MR = 15'b1000000_00_00_0_010;
  localparam logic [14:0] MB = 15'b0000110_00_00_0_010;
  localparam logic [14:0] MW = 15'b1100000_00_00_0_010;
  localparam logic [14:0] AW = 15'b0001010_00_00_0_010;
  localparam logic [14:0] IW = 15'b0000010_00_00_0_010;
  localparam logic [14:0] JP = 15'b0000000_00_10_1_010;
  localparam logic [14:0] BR0 = 15'b0000001_00_01_0_110;
  localparam logic [14:0] BR1 = 15'b0000001_00_01_1_110;
  localparam logic [11:0] EXB = 12'b0000001_00_00_0;

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        z;
    logic [3:0]  st;
    logic [14:0] out;
  } vec_t;
  vec_t v[$];

  task automatic add(input logic [5:0] op, input logic [5:0] fn, input logic z,
                     input logic [3:0] st, input logic [14:0] out);
    vec_t r;
    r.op = op; r.fn = fn; r.z = z; r.st = st; r.out = out;
    v.push_back(r);
  endtask

  task automatic check(input string name, input logic [3:0] est, input logic [14:0] eout);
    checks += 2;
    if (state !== est) begin
      failures++;
      $display("FAIL %s state: got %0d expected %0d", name, state, est);
    end
    if (got !== eout) begin
      failures++;
      $display("FAIL %s outputs: got %b expected %b (state %0d)", name, got, eout, state);
    end
  endtask

  task automatic add_rtype(input logic [5:0] fn, input logic [2:0] ac);
    add(6'b000000, fn, 1'b0, 4'd0, FE);
    add(6'b000000, fn, 1'b0, 4'd1, DE);
    add(6'b000000, fn, 1'b0, 4'd6, {EXB, ac});
    add(6'b000000, fn, 1'b0, 4'd7, AW);
  endtask

  initial begin
    // lw
    add(6'b100011, 6'd0, 1'b0, 4'd0, FE);
    add(6'b100011, 6'd0, 1'b0, 4'd1, DE);
    add(6'b100011, 6'd0, 1'b0, 4'd2, MA);
    add(6'b100011, 6'd0, 1'b0, 4'd3, MR);
    add(6'b100011, 6'd0, 1'b0, 4'd4, MB);
    // sw
    add(6'b101011, 6'd0, 1'b0, 4'd0, FE);
    add(6'b101011, 6'd0, 1'b0, 4'd1, DE);
    add(6'b101011, 6'd0, 1'b0, 4'd2, MA);
    add(6'b101011, 6'd0, 1'b0, 4'd5, MW);
    // R-type across every funct decode plus an unknown funct
    add_rtype(6'b101010, 3'b111);
    add_rtype(6'b100000, 3'b010);
    add_rtype(6'b100010, 3'b110);
    add_rtype(6'b100100, 3'b000);
    add_rtype(6'b100101, 3'b001);
    add_rtype(6'b000111, 3'b010);
    // addi with a funct pattern that must not affect the decode
    add(6'b001000, 6'b101010, 1'b0, 4'd0, FE);
    add(6'b001000, 6'b101010, 1'b0, 4'd1, DE);
    add(6'b001000, 6'b101010, 1'b0, 4'd9, MA);
    add(6'b001000, 6'b101010, 1'b0, 4'd10, IW);
    // beq taken, zero ignored outside BRANCH
    add(6'b000100, 6'd0, 1'b1, 4'd0, FE);
    add(6'b000100, 6'd0, 1'b1, 4'd1, DE);
    add(6'b000100, 6'b100101, 1'b1, 4'd8, BR1);
    // beq not taken
    add(6'b000100, 6'd0, 1'b0, 4'd0, FE);
    add(6'b000100, 6'd0, 1'b0, 4'd1, DE);
    add(6'b000100, 6'd0, 1'b0, 4'd8, BR0);
    // j
    add(6'b000010, 6'd0, 1'b0, 4'd0, FE);
    add(6'b000010, 6'd0, 1'b0, 4'd1, DE);
    add(6'b000010, 6'd0, 1'b0, 4'd11, JP);
    // unknown opcode skipped
    add(6'b111111, 6'd0, 1'b1, 4'd0, FE);
    add(6'b111111, 6'd0, 1'b1, 4'd1, DE);
    // lw again, interrupted by reset in MEMRD
    add(6'b100011, 6'd0, 1'b0, 4'd0, FE);
    add(6'b100011, 6'd0, 1'b0, 4'd1, DE);
    add(6'b100011, 6'd0, 1'b0, 4'd2, MA);

    #2;
    check("reset_hold", 4'd0, FE);
    @(posedge clk);
    #1 check("reset_hold_edge", 4'd0, FE);
    @(negedge clk);
    reset = 1'b0;
    foreach (v[i]) begin
      opcode = v[i].op;
      funct  = v[i].fn;
      zero   = v[i].z;
      #1 check($sformatf("vec%0d", i), v[i].st, v[i].out);
      @(negedge clk);
    end

    // now in MEMRD: async reset between edges
    opcode = 6'b100011;
    #1 check("pre_reset_memrd", 4'd3, MR);
    #1 reset = 1'b1;
    #1 check("async_reset", 4'd0, FE);
    @(posedge clk);
    #1 check("reset_held", 4'd0, FE);
    @(negedge clk);
    reset = 1'b0;
    #1 check("after_release", 4'd0, FE);
    @(posedge clk);
    #1 check("first_decode", 4'd1, DE);
    @(posedge clk);
    #1 check("restart_memadr", 4'd2, MA);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
